// File: rtl/irq_pkg.sv
// Shared types, default handler vectors and the priority encoder for the
// interrupt controller.
package irq_pkg;

  localparam int N_SRC = 3;
  localparam int ID_W  = 2;

  localparam logic [31:0] VEC0_DEFAULT = 32'h0000_0C00;
  localparam logic [31:0] VEC1_DEFAULT = 32'h0000_0D00;
  localparam logic [31:0] VEC2_DEFAULT = 32'h0000_0E00;

  typedef logic [N_SRC-1:0] irq_vec_t;
  typedef logic [ID_W-1:0]  irq_id_t;

  typedef struct packed {
    logic    valid;
    irq_id_t idx;
  } prio_t;

  // Highest set bit wins: the ascending scan lets later (higher) bits overwrite.
  function automatic prio_t prio_enc(input irq_vec_t v);
    prio_t r;
    r = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (v[i]) begin
        r.valid = 1'b1;
        r.idx   = irq_id_t'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// CPU-facing request/acknowledge/return signals of the interrupt controller.
interface irq_ctrl_if;
  import irq_pkg::*;

  logic        en;
  logic        int_ack;
  logic        eret;
  logic        int_req;
  irq_id_t     int_id;
  logic [31:0] int_vec;

  // The controller is the requesting end; the CPU only answers.
  modport master (
    input  en,
    input  int_ack,
    input  eret,
    output int_req,
    output int_id,
    output int_vec
  );

  modport slave (
    output en,
    output int_ack,
    output eret,
    input  int_req,
    input  int_id,
    input  int_vec
  );

endinterface

// File: rtl/irq_sync_edge.sv
// Multi-flop synchroniser for one asynchronous request line followed by a
// rising-edge detector producing a single-cycle pulse.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic in_RST,
  input  logic irq_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  always_ff @(posedge clk) begin
    if (in_RST) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], irq_in};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  // A level held high yields exactly one pulse, on its first synced cycle.
  assign rise = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/irq_ctrl.sv
// Prioritised, nestable interrupt controller: latches request edges as pending,
// arbitrates against the in-service level and tracks ack/return from the CPU.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter logic [31:0] VEC0        = VEC0_DEFAULT,
  parameter logic [31:0] VEC1        = VEC1_DEFAULT,
  parameter logic [31:0] VEC2        = VEC2_DEFAULT,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              in_RST,
  input  irq_vec_t          irq_in,
  irq_ctrl_if.master        bus,
  output irq_vec_t          pending,
  output irq_vec_t          in_service
);

  irq_vec_t rise;
  irq_vec_t pending_reg, pending_next;
  irq_vec_t in_service_reg, in_service_next;
  irq_vec_t ack_onehot;
  irq_vec_t ret_onehot;

  prio_t       cur;
  prio_t       cand;
  logic        req;
  logic        ack_fire;
  logic        ret_fire;
  logic [31:0] vec_sel;

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_src
      irq_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
      ) u_sync_edge (
        .clk    (clk),
        .in_RST (in_RST),
        .irq_in (irq_in[gi]),
        .rise   (rise[gi])
      );
    end
  endgenerate

  // Arbitration sees registered state only, so ack/eret never loop back
  // combinationally into int_req/int_id/int_vec.
  assign cur  = prio_enc(in_service_reg);
  assign cand = prio_enc(pending_reg);
  assign req  = cand.valid && (!cur.valid || (cand.idx > cur.idx));

  assign ack_fire = bus.en & bus.int_ack & req;
  assign ret_fire = bus.en & bus.eret & cur.valid;

  assign ack_onehot = ack_fire ? (irq_vec_t'(1) << cand.idx) : '0;
  assign ret_onehot = ret_fire ? (irq_vec_t'(1) << cur.idx)  : '0;

  // Return clears before ack sets; an ack always targets a level above cur,
  // so the two never touch the same bit. A fresh edge beats the ack's clear.
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_next
      assign pending_next[gi]    = rise[gi] | (pending_reg[gi] & ~ack_onehot[gi]);
      assign in_service_next[gi] = (in_service_reg[gi] & ~ret_onehot[gi]) | ack_onehot[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (in_RST) begin
      pending_reg    <= '0;
      in_service_reg <= '0;
    end else begin
      pending_reg    <= pending_next;
      in_service_reg <= in_service_next;
    end
  end

  always_comb begin
    vec_sel = VEC2;
    case (cand.idx)
      irq_id_t'(0): vec_sel = VEC0;
      irq_id_t'(1): vec_sel = VEC1;
      default:      vec_sel = VEC2;
    endcase
  end

  always_comb begin
    bus.int_req = req;
    bus.int_id  = req ? cand.idx : '0;
    bus.int_vec = req ? vec_sel  : '0;
  end

  assign pending    = pending_reg;
  assign in_service = in_service_reg;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: each step queues the expected post-edge state,
// then the DUT state after the edge is popped against it.
module tb_irq_ctrl;
  import irq_pkg::*;

  logic     clk = 1'b0;
  logic     in_RST;
  irq_vec_t irq_in;
  irq_vec_t pending;
  irq_vec_t in_service;

  irq_ctrl_if bus ();

  irq_ctrl dut (
    .clk        (clk),
    .in_RST     (in_RST),
    .irq_in     (irq_in),
    .bus        (bus),
    .pending    (pending),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    string       tag;
    logic        req;
    logic [1:0]  id;
    logic [31:0] vec;
    logic [2:0]  pend;
    logic [2:0]  insvc;
  } exp_t;

  exp_t sb[$];

  function automatic logic [31:0] vec_of(input int id);
    case (id)
      0:       return 32'h0000_0C00;
      1:       return 32'h0000_0D00;
      2:       return 32'h0000_0E00;
      default: return 32'h0;
    endcase
  endfunction

  task automatic cmp(input string tag, input string field,
                     input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
    end
  endtask

  task automatic expect_state(input string tag, input int req, input int id,
                              input int pend, input int insvc);
    exp_t e;
    e.tag   = tag;
    e.req   = (req != 0);
    e.id    = (req != 0) ? 2'(id) : 2'd0;
    e.vec   = (req != 0) ? vec_of(id) : 32'h0;
    e.pend  = 3'(pend);
    e.insvc = 3'(insvc);
    sb.push_back(e);
  endtask

  task automatic check_next();
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      failed++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      cmp(e.tag, "int_req",    32'(bus.int_req), 32'(e.req));
      cmp(e.tag, "int_id",     32'(bus.int_id),  32'(e.id));
      cmp(e.tag, "int_vec",    bus.int_vec,      e.vec);
      cmp(e.tag, "pending",    32'(pending),     32'(e.pend));
      cmp(e.tag, "in_service", 32'(in_service),  32'(e.insvc));
      $display("[TB] %-12s req=%0d id=%0d vec=%h pend=%b insvc=%b",
               e.tag, bus.int_req, bus.int_id, bus.int_vec, pending, in_service);
    end
  endtask

  // One clock edge with the current inputs, then compare against the queue.
  task automatic step(input string tag, input int req, input int id,
                      input int pend, input int insvc);
    expect_state(tag, req, id, pend, insvc);
    @(posedge clk);
    #1;
    check_next();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_RST      = 1'b1;
    irq_in      = 3'b111;
    bus.en      = 1'b1;
    bus.int_ack = 1'b0;
    bus.eret    = 1'b0;

    // Reset with all lines high, then the 3-edge sync latency.
    step("rst0",    0, 0, 3'b000, 3'b000);
    step("rst1",    0, 0, 3'b000, 3'b000);
    in_RST = 1'b0;
    step("sync1",   0, 0, 3'b000, 3'b000);
    step("sync2",   0, 0, 3'b000, 3'b000);
    step("pend3",   1, 2, 3'b111, 3'b000);
    irq_in = 3'b000; bus.int_ack = 1'b1;
    step("ack_hi",  0, 0, 3'b011, 3'b100);
    bus.int_ack = 1'b0; in_RST = 1'b1;
    step("rst_mid", 0, 0, 3'b000, 3'b000);
    in_RST = 1'b0;

    // Single request on source 0.
    irq_in = 3'b001;
    step("s_sync1", 0, 0, 3'b000, 3'b000);
    step("s_sync2", 0, 0, 3'b000, 3'b000);
    step("s_req",   1, 0, 3'b001, 3'b000);
    irq_in = 3'b000; bus.int_ack = 1'b1;
    step("s_ack",   0, 0, 3'b000, 3'b001);
    bus.int_ack = 1'b0; bus.eret = 1'b1;
    step("s_ret",   0, 0, 3'b000, 3'b000);
    bus.eret = 1'b0;

    // Nesting: source 2 pre-empts source 0.
    irq_in = 3'b001;
    step("n_sync1", 0, 0, 3'b000, 3'b000);
    step("n_sync2", 0, 0, 3'b000, 3'b000);
    step("n_req0",  1, 0, 3'b001, 3'b000);
    bus.int_ack = 1'b1;
    step("n_ack0",  0, 0, 3'b000, 3'b001);
    bus.int_ack = 1'b0; irq_in = 3'b101;
    step("n_sync3", 0, 0, 3'b000, 3'b001);
    step("n_sync4", 0, 0, 3'b000, 3'b001);
    step("n_req2",  1, 2, 3'b100, 3'b001);
    bus.int_ack = 1'b1;
    step("n_ack2",  0, 0, 3'b000, 3'b101);
    bus.int_ack = 1'b0; bus.eret = 1'b1;
    step("n_ret2",  0, 0, 3'b000, 3'b001);
    step("n_ret0",  0, 0, 3'b000, 3'b000);
    bus.eret = 1'b0; irq_in = 3'b000;
    step("n_idle",  0, 0, 3'b000, 3'b000);

    // Blocking: source 1 waits behind source 2 until its return.
    irq_in = 3'b100;
    step("b_sync1", 0, 0, 3'b000, 3'b000);
    step("b_sync2", 0, 0, 3'b000, 3'b000);
    step("b_req2",  1, 2, 3'b100, 3'b000);
    bus.int_ack = 1'b1;
    step("b_ack2",  0, 0, 3'b000, 3'b100);
    bus.int_ack = 1'b0; irq_in = 3'b010;
    step("b_sync3", 0, 0, 3'b000, 3'b100);
    step("b_sync4", 0, 0, 3'b000, 3'b100);
    step("b_pend1", 0, 0, 3'b010, 3'b100);
    step("b_wait",  0, 0, 3'b010, 3'b100);
    bus.eret = 1'b1;
    step("b_ret",   1, 1, 3'b010, 3'b000);
    bus.eret = 1'b0;

    // Ignored ack/return cases.
    irq_in = 3'b000; bus.en = 1'b0; bus.int_ack = 1'b1;
    step("c_ack_dis",   1, 1, 3'b010, 3'b000);
    bus.en = 1'b1;
    step("c_ack1",      0, 0, 3'b000, 3'b010);
    step("c_ack_noreq", 0, 0, 3'b000, 3'b010);
    bus.int_ack = 1'b0; bus.en = 1'b0; bus.eret = 1'b1;
    step("c_ret_dis",   0, 0, 3'b000, 3'b010);
    bus.en = 1'b1;
    step("c_ret",       0, 0, 3'b000, 3'b000);
    step("c_ret_empty", 0, 0, 3'b000, 3'b000);
    bus.eret = 1'b0;

    // Ack of source 1 in the same cycle as a new source-1 edge.
    irq_in = 3'b010;
    step("x_s1",        0, 0, 3'b000, 3'b000);
    irq_in = 3'b000;
    step("x_s2",        0, 0, 3'b000, 3'b000);
    irq_in = 3'b010;
    step("x_pend",      1, 1, 3'b010, 3'b000);
    step("x_hold",      1, 1, 3'b010, 3'b000);
    bus.int_ack = 1'b1;
    step("x_ack_edge",  0, 0, 3'b010, 3'b010);
    bus.int_ack = 1'b0; bus.eret = 1'b1;
    step("x_ret",       1, 1, 3'b010, 3'b000);
    bus.eret = 1'b0; bus.int_ack = 1'b1;
    step("x_ack",       0, 0, 3'b000, 3'b010);
    bus.int_ack = 1'b0; bus.eret = 1'b1;
    step("x_done",      0, 0, 3'b000, 3'b000);
    bus.eret = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Prioritised, nestable interrupt controller that feeds the five-stage pipeline CPU. Synchronises and edge-detects three external request lines (board switches/buttons) and latches them as pending. It presents one vectored request to the CPU, accepts the CPU's acknowledge when the PC is redirected to the handler, and retires the in-service level when the CPU commits `eret` in WB. It is the requesting end of the CPU's `eret`/EPC return path: the CPU only responds and returns; this block decides who interrupts and when.

## Interface
- `N_SRC`, 3: number of sources; index 2 has the highest priority.
- `VEC0`, 32'h0000_0C00: handler address for source 0.
- `VEC1`, 32'h0000_0D00: handler address for source 1.
- `VEC2`, 32'h0000_0E00: handler address for source 2.
- `SYNC_STAGES`, 2: synchroniser flops per source (≥2).

- `clk  in  1`: system clock; all state changes on the rising edge.
- `in_RST  in  1`: reset. Synchronous and active-high.
- `en  in  1`: pipeline enable (`~WB_lock`). `int_ack` and `eret` are ignored while `en`=0.
- `irq_in  in  N_SRC`: raw asynchronous request lines, level-high.
- `int_ack  in  1`: CPU has taken the request shown this cycle.
- `eret  in  1`: CPU commits `eret` in WB.
- `int_req  out  1`: request to CPU.
- `int_id  out  2`: source index being requested; 0 when `int_req`=0.
- `int_vec  out  32`: handler address for `int_id`; 0 when `int_req`=0.
- `pending  out  N_SRC`: latched, un-acknowledged edges.
- `in_service  out  N_SRC`: acknowledged, not yet returned levels.

## Operation
- Per source: a `SYNC_STAGES`-deep synchroniser, then a rising-edge detector (synced bit vs. its registered previous value). An edge sets `pending[i]`. Levels held high produce one edge only.
- Current level `cur` = index of the highest set `in_service` bit, or −1 if none.
- Candidate `cand` = index of the highest set `pending` bit.
- `int_req` = `pending≠0` AND `cand > cur`. Lower or equal priority waits; higher priority pre-empts (nesting).
- `int_req`, `int_id` and `int_vec` are combinational from registered state only. There is no combinational path from `int_ack` or `eret`.
- Ack (`en & int_ack & int_req`): clear `pending[int_id]` and set `in_service[int_id]`. An ack while `int_req`=0 is ignored.
- Return (`en & eret`): clear the highest set `in_service` bit. A return while `in_service`=0 is ignored.
- Simultaneous events in one cycle, resolved in this order:
  - the return clears first;
  - the ack applies to the `int_id` computed from pre-edge state;
  - a new edge on the same source as the ack leaves `pending[i]`=1 (set wins over clear).
- `in_RST` clears all synchroniser, edge, pending and in-service state. This holds mid-handler: outstanding levels are discarded, and the CPU's own reset restarts the PC.

## Timing
- Reset values: `int_req`=0, `int_id`=0, `int_vec`=0, `pending`=0, `in_service`=0.
- Latency with `SYNC_STAGES`=2: `irq_in` rising before edge k is sampled at k, synced at k+1, and sets `pending` at k+2. `int_req` is high in the cycle after edge k+2.
- After an ack at edge a: `int_req` is low in cycle a+1, unless another eligible source is pending.
- After a return at edge r: a lower-priority pending source may request in cycle r+1.
- `int_id`/`int_vec` may change while `int_req` stays high, when a higher source becomes pending before the ack. The CPU must sample them in the ack cycle.
- Throughput: one ack and one return per cycle maximum.

## Structure
- Package `irq_pkg`:
  - `N_SRC`;
  - vector constants;
  - `function prio_enc` (highest-set-bit index plus valid flag);
  - `typedef logic [N_SRC-1:0] irq_vec_t`.
- Sub-module `irq_sync_edge`: synchroniser chain plus rising-edge pulse, one instance per source.
- Top `irq_ctrl` contains the pending/in-service registers and the arbitration logic.

## Test plan
- Reset then idle: hold `in_RST`=1 for 2 cycles with `irq_in`=3'b111 → all outputs 0. After release, `pending`=3'b111 no sooner than 3 edges later, then `int_req`=1, `int_id`=2, `int_vec`=32'h0E00.
- Single request: pulse `irq_in[0]`, ack in the first `int_req` cycle → `pending`=0, `in_service`=3'b001, `int_req`=0. Then `eret` → `in_service`=0.
- Nesting: source 0 in service, raise `irq_in[2]` → `int_req`=1 with `int_id`=2. Ack → `in_service`=3'b101. First `eret` → 3'b001; second `eret` → 0.
- Blocking: source 2 in service, pulse `irq_in[1]` → `pending`=3'b010 and `int_req`=0 until `eret`; then `int_id`=1 one cycle later.
- Corner cases:
  - ack with `en`=0, or while `int_req`=0 → no state change;
  - ack of source 1 and a new source-1 edge in the same cycle → `pending[1]` stays 1 and `in_service[1]`=1;
  - `eret` with `in_service`=0 → ignored.
